// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES key-schedule constants, Rcon table, FSM states and word helpers
package aes_pkg;

  localparam int KEY_W  = 128;
  localparam int WORD_W = 32;

  localparam logic [7:0] RCON [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ks_state_t;

  // Indices past the table only occur on the unused step at round 0.
  function automatic logic [7:0] rcon(input logic [3:0] i);
    if (i < 4'd10) return RCON[i];
    return 8'h00;
  endfunction

  function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Word 0 is the most significant word of the key.
  function automatic logic [WORD_W-1:0] key_word(input logic [KEY_W-1:0] key, input int i);
    return key[KEY_W-1-WORD_W*i -: WORD_W];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - forward AES S-box, one byte in, one byte out
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX[a];

endmodule

// File: rtl/inv_key_schedule.sv
// rtl/inv_key_schedule.sv - backward AES-128 key expansion, round key 10 down to 0
module inv_key_schedule #(
  parameter int KEY_W      = aes_pkg::KEY_W,
  parameter int NUM_ROUNDS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] final_key,
  input  logic             rd_ready,
  output logic             key_valid,
  output logic [KEY_W-1:0] round_key,
  output logic [3:0]       round_idx,
  output logic             busy,
  output logic             done
);

  import aes_pkg::*;

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  ks_state_t        state_q, state_d;
  logic [KEY_W-1:0] key_q, next_key;
  logic [3:0]       idx_q;
  logic             load, step;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] p0, p1, p2, p3;
  logic [31:0] rot, sub;

  // Undo one forward step: words 1..3 of the previous key fall out of xors,
  // word 0 needs the g() function applied to the recovered word 3.
  assign w0  = key_word(key_q, 0);
  assign w1  = key_word(key_q, 1);
  assign w2  = key_word(key_q, 2);
  assign w3  = key_word(key_q, 3);
  assign p3  = w3 ^ w2;
  assign p2  = w2 ^ w1;
  assign p1  = w1 ^ w0;
  assign rot = rot_word(p3);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .a (rot[8*g +: 8]),
      .y (sub[8*g +: 8])
    );
  end

  assign p0       = w0 ^ sub ^ {rcon(idx_q - 4'd1), 24'h0};
  assign next_key = {p0, p1, p2, p3};

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    step      = 1'b0;
    key_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        key_valid = 1'b1;
        if (rd_ready) begin
          if (idx_q == 4'd0) state_d = ST_DONE;
          else               step    = 1'b1;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      idx_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      if (load) begin
        key_q <= final_key;
        idx_q <= LAST_IDX;
      end else if (step) begin
        key_q <= next_key;
        idx_q <= idx_q - 4'd1;
      end
    end
  end

  assign round_key = key_q;
  assign round_idx = idx_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// tb/tb_inv_key_schedule.sv - self-checking bench for inv_key_schedule
module tb_inv_key_schedule;

  logic         clk = 1'b0;
  logic         rst, start, rd_ready;
  logic [127:0] final_key;
  logic         key_valid, busy, done;
  logic [127:0] round_key;
  logic [3:0]   round_idx;

  int n_checks = 0;
  int n_fail = 0;
  int hs_count = 0;
  int done_count = 0;
  bit mon_on = 1'b0;

  logic [7:0]   sbox_tab [256];
  logic [127:0] exp_keys [11];

  localparam logic [127:0] CK_STD = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K10_STD = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K9_STD = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] K10_ZERO = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  always #5 clk = ~clk;

  inv_key_schedule #(.KEY_W(128), .NUM_ROUNDS(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .final_key (final_key),
    .rd_ready  (rd_ready),
    .key_valid (key_valid),
    .round_key (round_key),
    .round_idx (round_idx),
    .busy      (busy),
    .done      (done)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (gmul(8'(v), 8'(c)) == 8'h01) inv = 8'(c);
      sbox_tab[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  // Forward expansion of a cipher key; exp_keys[r] is round key r.
  task automatic expand_key(input logic [127:0] ck);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = ck[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]}
            ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    int         m_st = 0;
    logic [3:0] m_idx = 4'd0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        chk("key_valid", 128'(key_valid), 128'(m_st == 1));
        chk("busy", 128'(busy), 128'(m_st != 0));
        chk("done", 128'(done), 128'(m_st == 2));
        if (m_st == 1) begin
          chk("round_idx", 128'(round_idx), 128'(m_idx));
          chk("round_key", round_key, exp_keys[m_idx]);
        end
        if (key_valid && rd_ready && !rst) hs_count++;
        if (done) done_count++;
        if (rst) m_st = 0;
        else begin
          case (m_st)
            0: if (start) begin m_st = 1; m_idx = 4'd10; end
            1: if (rd_ready) begin
                 if (m_idx == 4'd0) m_st = 2;
                 else m_idx = m_idx - 4'd1;
               end
            default: m_st = 0;
          endcase
        end
      end
    end
  endtask

  task automatic run_timed(output int nvalid, output int done_cyc, output logic [127:0] last0);
    start = 1'b1;
    tick();
    start = 1'b0;
    nvalid = 0;
    done_cyc = 0;
    last0 = 'x;
    for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
      if (done) done_cyc = c;
      else begin
        if (key_valid) nvalid++;
        if (key_valid && round_idx == 4'd0) last0 = round_key;
        tick();
      end
    end
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      if (done) seen = 1'b1;
      else tick();
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_key_valid"}, 128'(key_valid), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_done"}, 128'(done), 128'(0));
    chk({tag, "_round_key"}, round_key, 128'h0);
    chk({tag, "_round_idx"}, 128'(round_idx), 128'(0));
  endtask

  initial begin
    int           hs0, dn0, nvalid, dcyc;
    logic [127:0] last0, ck;
    bit           seen;

    fork
      monitor();
    join_none

    rst = 1'b1;
    start = 1'b1;
    rd_ready = 1'b1;
    final_key = {4{32'hffff_ffff}};
    build_sbox();
    tick();
    tick();
    chk_idle_zero("reset");
    rst = 1'b0;
    start = 1'b0;
    mon_on = 1'b1;

    expand_key(128'h0);
    chk("model_zero_k10", exp_keys[10], K10_ZERO);
    expand_key(CK_STD);
    chk("model_k10", exp_keys[10], K10_STD);
    chk("model_k9", exp_keys[9], K9_STD);

    // Full-rate run of the standard key.
    final_key = exp_keys[10];
    rd_ready = 1'b1;
    hs0 = hs_count;
    run_timed(nvalid, dcyc, last0);
    chk("std_valid_cycles", 128'(nvalid), 128'(11));
    chk("std_done_cycle", 128'(dcyc), 128'(12));
    chk("std_idx0_key", last0, CK_STD);
    tick();
    chk("std_handshakes", 128'(hs_count - hs0), 128'(11));

    // Stall at index 9.
    hs0 = hs_count;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rd_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      chk("stall_idx", 128'(round_idx), 128'(9));
      chk("stall_key", round_key, K9_STD);
      tick();
    end
    rd_ready = 1'b1;
    wait_done(40, seen);
    chk("stall_done_seen", 128'(seen), 128'(1));
    tick();
    chk("stall_handshakes", 128'(hs_count - hs0), 128'(11));

    // All-zero cipher key.
    expand_key(128'h0);
    final_key = exp_keys[10];
    run_timed(nvalid, dcyc, last0);
    chk("zero_idx0_key", last0, 128'h0);
    chk("zero_done_cycle", 128'(dcyc), 128'(12));
    tick();

    // Reset mid-expansion at index 5, with a handshake in the same cycle.
    expand_key(CK_STD);
    final_key = exp_keys[10];
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      if (key_valid && round_idx == 4'd5) seen = 1'b1;
      else tick();
    end
    chk("rst_reached_idx5", 128'(seen), 128'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle_zero("midrst");
    run_timed(nvalid, dcyc, last0);
    chk("restart_valid_cycles", 128'(nvalid), 128'(11));
    chk("restart_done_cycle", 128'(dcyc), 128'(12));
    chk("restart_idx0_key", last0, CK_STD);
    tick();

    // start pulses while busy must be ignored.
    hs0 = hs_count;
    dn0 = done_count;
    start = 1'b1;
    tick();
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      start = (key_valid && (round_idx == 4'd3 || round_idx == 4'd0)) || done;
      if (done) seen = 1'b1;
      tick();
    end
    start = 1'b0;
    chk("busy_start_after_done", 128'(busy), 128'(0));
    tick();
    tick();
    chk("busy_start_stays_idle", 128'(key_valid), 128'(0));
    chk("busy_start_handshakes", 128'(hs_count - hs0), 128'(11));
    chk("busy_start_done_pulses", 128'(done_count - dn0), 128'(1));

    // Random keys with random back-pressure.
    for (int k = 0; k < 100; k++) begin
      ck = {$urandom, $urandom, $urandom, $urandom};
      expand_key(ck);
      final_key = exp_keys[10];
      hs0 = hs_count;
      rd_ready = 1'($urandom_range(0, 1));
      start = 1'b1;
      tick();
      start = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 400 && !seen; c++) begin
        if (done) seen = 1'b1;
        else begin
          rd_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
      chk("rand_done_seen", 128'(seen), 128'(1));
      tick();
      chk("rand_handshakes", 128'(hs_count - hs0), 128'(11));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inv_key_schedule.md
INV_KEY_SCHEDULE -- requirements
Module: inv_key_schedule

Interface
REQ-001 Parameter: KEY_W, default 128, round-key width in bits.
REQ-002 Parameter: NUM_ROUNDS, default 10, last round index.
REQ-003 Port: clk  input  1  sole clock; all logic on rising edge.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: start  input  1  request to begin a backward expansion; sampled only in IDLE.
REQ-006 Port: final_key  input  128  round-10 key; captured on the accepted start.
REQ-007 Port: rd_ready  input  1  consumer (decrypt datapath) ready for the current round key.
REQ-008 Port: key_valid  output  1  round_key/round_idx valid.
REQ-009 Port: round_key  output  128  current round key, word 0 in bits [127:96].
REQ-010 Port: round_idx  output  4  index of round_key, 10 down to 0.
REQ-011 Port: busy  output  1  high in every state except IDLE.
REQ-012 Port: done  output  1  one-cycle pulse after round key 0 is accepted.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on the handshake at round_idx 0; DONE->IDLE unconditionally after one cycle.
REQ-014 A start in IDLE SHALL load final_key into the key register; key_valid SHALL go high the next cycle with round_idx=10 and round_key=final_key.
REQ-015 A handshake SHALL be a cycle with key_valid && rd_ready; only a handshake advances the key register and decrements round_idx.
REQ-016 While key_valid && !rd_ready, round_key and round_idx SHALL hold stable, with no limit on stall length.
REQ-017 Key order SHALL be 10,9,...,0; one key per cycle when rd_ready stays high, so 11 keys take 11 consecutive cycles.
REQ-018 Step r->r-1, words w0..w3 of key r: p3=w3^w2, p2=w2^w1, p1=w1^w0, p0=w0^SubWord(RotWord(p3))^{Rcon[r-1],24'h0}.
REQ-019 Rcon[0..9] SHALL be 01,02,04,08,10,20,40,80,1B,36, giving round-key-0 output identical to the original cipher key.
REQ-020 The step SHALL be purely combinational from the key register into a registered update, so round_key is always driven from a flop.
REQ-021 key_valid SHALL be low in DONE and IDLE; done SHALL be high only in DONE.
REQ-022 start SHALL be ignored while busy, including in the DONE cycle and in the same cycle as the final handshake.
REQ-023 rd_ready while key_valid is low SHALL have no effect.
REQ-024 round_idx SHALL never wrap below 0; no step is computed after index 0.

Reset
REQ-025 On rst, in any state including mid-expansion, the FSM SHALL go to IDLE and key_valid, busy, and done SHALL be 0, round_key 128'h0, round_idx 4'd0, on the following edge.
REQ-026 rst SHALL take priority over start and over a handshake in the same cycle.

Structure
REQ-027 Package aes_pkg SHALL hold the KEY_W constant, the Rcon table, the FSM state enum, and the RotWord/word-split helpers.
REQ-028 The S-box SHALL be the sub-module aes_sbox (forward S-box, 8-bit in/out), with four instances for SubWord.
REQ-029 The block SHALL have one clock domain and no latches.

Verification
REQ-030 final_key=d014f9a8c9ee2589e13f0cc8b6630ca6, rd_ready=1 -> keys on 11 consecutive cycles: idx10=d014..., idx9=ac7766f319fadc2128d12941575c006e, idx0=2b7e151628aed2a6abf7158809cf4f3c; done on the 12th cycle.
REQ-031 Same key with rd_ready low for 3 cycles at idx 9 -> round_key holds ac7766f3... and idx 9 for 3 cycles, then the sequence resumes unchanged.
REQ-032 final_key=b4ef5bcb3e92e21123e951cf6f8f188e -> idx0 key=128'h0.
REQ-033 rst asserted at idx 5 -> next cycle IDLE, all outputs 0; a new start then produces idx 10 again.
REQ-034 start pulsed during RUN and during DONE -> ignored; exactly 11 handshakes and one done pulse.
REQ-035 Randomized rd_ready over 100 random keys -> the 11 keys match a reference forward expansion in reverse order.
